// File: rtl/buf_reader_stream_if.sv
// buf_reader_stream_if: Wishbone read bus plus the outgoing pixel stream of buf_reader_stream.
// The master modport is the reader; the slave modport is the memory plus the panel consumer.
interface buf_reader_stream_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] wbm_address;
  logic [DATA_WIDTH-1:0] wbm_writedata;
  logic [DATA_WIDTH-1:0] wbm_readdata;
  logic                  wbm_strobe;
  logic                  wbm_cycle;
  logic                  wbm_write;
  logic                  wbm_ack;
  logic [23:0]           pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_eol;
  logic                  pix_eof;

  modport master (
    output wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    input  wbm_readdata, wbm_ack,
    output pix_data, pix_valid, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    output wbm_readdata, wbm_ack,
    input  pix_data, pix_valid, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/buf_reader_stream.sv
// buf_reader_stream: reads one frame buffer over Wishbone in raster order and streams each
// pixel out on a valid/ready interface with end-of-line / end-of-frame markers.
// Optional feature macro: BUF_READER_ACK_TIMEOUT_EN (ack timeout with sticky rd_error).
`ifndef IMG_WIDTH
`define IMG_WIDTH 64
`endif
`ifndef IMG_HEIGHT
`define IMG_HEIGHT 32
`endif

module buf_reader_stream #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned IMG_WIDTH   = `IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT  = `IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] buf_id,
  input  logic                  read_buf,
  output logic                  buf_read,
  output logic                  busy,
  output logic                  rd_error,
  buf_reader_stream_if.master   bus
);

  localparam int unsigned PixStep    = DATA_WIDTH / 8;
  localparam int unsigned FrameBytes = IMG_WIDTH * IMG_HEIGHT * PixStep;

  typedef enum logic [2:0] {StIdle, StInit, StRead, StPush, StNext, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [23:0]           pix_q, pix_d;
  logic                  last_col, last_row;
  logic                  timeout;
  logic                  rd_start;

  // Buffers are laid out back to back, one frame of pixel words each; wraps with the bus.
  function automatic logic [ADDR_WIDTH-1:0] addr_for_buf_id(input logic [DATA_WIDTH-1:0] id);
    return ADDR_WIDTH'(id) * ADDR_WIDTH'(FrameBytes);
  endfunction

  assign last_col = (col_q == ADDR_WIDTH'(IMG_WIDTH - 1));
  assign last_row = (row_q == ADDR_WIDTH'(IMG_HEIGHT - 1));
  assign rd_start = (state_q == StIdle) && read_buf;

  // Next-state and datapath updates for the read/push sequence.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    case (state_q)
      StIdle: begin
        if (read_buf) state_d = StInit;
      end
      StInit: begin
        row_d   = '0;
        col_d   = '0;
        addr_d  = addr_for_buf_id(buf_id);
        state_d = StRead;
      end
      StRead: begin
        // An ack in the timeout cycle still completes the read.
        if (bus.wbm_ack) begin
          pix_d   = bus.wbm_readdata[23:0];
          state_d = StPush;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StPush: begin
        if (bus.pix_ready) state_d = (last_row && last_col) ? StDone : StNext;
      end
      StNext: begin
        addr_d = addr_q + ADDR_WIDTH'(PixStep);
        if (last_col) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        state_d = StRead;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters, address and pixel registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
    end
  end

`ifdef BUF_READER_ACK_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  // Expires on the cycle the unacknowledged count would reach ACK_TIMEOUT.
  assign timeout = (state_q == StRead) && !bus.wbm_ack && (wait_q == WaitW'(ACK_TIMEOUT - 1));

  // Wait counter runs only inside READ; error is sticky until the next accepted start.
  always_comb begin
    wait_d = '0;
    if ((state_q == StRead) && !bus.wbm_ack) wait_d = wait_q + 1'b1;
    err_d = err_q;
    if (rd_start) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign rd_error = reset & err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(ACK_TIMEOUT), rd_start};
  assign timeout    = 1'b0;
  assign rd_error   = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.wbm_readdata[DATA_WIDTH-1:24], buf_id};

  // Outputs are decoded straight from state and forced low while reset is held.
  assign bus.wbm_cycle     = reset && (state_q == StRead);
  assign bus.wbm_strobe    = reset && (state_q == StRead);
  assign bus.wbm_write     = 1'b0;
  assign bus.wbm_writedata = '0;
  assign bus.wbm_address   = reset ? addr_q : '0;
  assign bus.pix_valid     = reset && (state_q == StPush);
  assign bus.pix_data      = reset ? pix_q : '0;
  assign bus.pix_eol       = reset && last_col;
  assign bus.pix_eof       = reset && last_col && last_row;
  assign buf_read          = reset && (state_q == StDone);
  assign busy              = reset && (state_q != StIdle);

endmodule

// File: tb/tb_buf_reader_stream.sv
// tb_buf_reader_stream: scoreboard bench; stimulus queues expected pixels, a negedge monitor
// pops and compares them on every valid cycle. Frame is 4x2, 4-byte pixel words.
module tb_buf_reader_stream;

  typedef struct packed {
    logic [23:0] data;
    logic        eol;
    logic        eof;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] buf_id = '0;
  logic        read_buf = 1'b0;
  logic        buf_read, busy, rd_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_wait = 0;
  int wait_cnt = 0;
  bit never_ack = 1'b0;
  int strobe_cnt = 0;
  int valid_cnt = 0;
  int buf_read_cnt = 0;
  int buf_read_cyc = 0;
  logic err_at_done = 1'b0;
  int hs_count = 0;
  int stall_seen = 0;
  int hs_cyc[$];
  pix_t exp_q[$];

  buf_reader_stream_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  buf_reader_stream #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .ACK_TIMEOUT(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)
  ) dut (
    .clk(clk), .reset(reset), .buf_id(buf_id), .read_buf(read_buf),
    .buf_read(buf_read), .busy(busy), .rd_error(rd_error), .bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: ack after ack_wait strobe cycles; data = address on the ack cycle, junk otherwise.
  assign bus.wbm_ack = bus.wbm_strobe && !never_ack && (wait_cnt == ack_wait);
  assign bus.wbm_readdata = bus.wbm_ack ? {16'h0000, bus.wbm_address} : 32'hA5A5_5A5A;
  always @(posedge clk) begin
    if (bus.wbm_strobe && !bus.wbm_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    pix_t e;
    if (reset) begin
      if (bus.wbm_strobe) begin
        strobe_cnt++;
        check("cycle_eq_strobe", 32'(bus.wbm_cycle), 32'd1);
      end
      if (buf_read) begin
        buf_read_cnt++;
        buf_read_cyc = cyc;
        err_at_done = rd_error;
      end
      if (bus.pix_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(bus.pix_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q[0];
          check("pix_data", 32'(bus.pix_data), 32'(e.data));
          check("pix_eol", 32'(bus.pix_eol), 32'(e.eol));
          check("pix_eof", 32'(bus.pix_eof), 32'(e.eof));
          if (bus.pix_ready) begin
            void'(exp_q.pop_front());
            hs_cyc.push_back(cyc);
            hs_count++;
          end else begin
            stall_seen++;
          end
        end
      end
    end
  end

  task automatic run_frame(input logic [31:0] id, input int wait_n, input int stall_pix,
                           input int stall_len, input int poke_at);
    int c0, br0, base, k;
    bit poked;
    poked = 1'b0;
    ack_wait = wait_n;
    base = int'(id) * 32;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{data: 24'((base + 4 * i) & 16'hFFFF), eol: (i % 4 == 3), eof: (i == 7)});
    hs_cyc.delete();
    hs_count = 0;
    stall_seen = 0;
    strobe_cnt = 0;
    br0 = buf_read_cnt;
    bus.pix_ready = 1'b1;
    @(posedge clk); #1;
    buf_id = id;
    read_buf = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    read_buf = 1'b0;
    check("rd_error_after_start", 32'(rd_error), 32'd0);
    k = 0;
    while (buf_read_cnt == br0 && k < 400) begin
      bus.pix_ready = !(hs_count == stall_pix && stall_seen < stall_len);
      if (!poked && poke_at >= 0 && hs_count == poke_at) begin
        read_buf = 1'b1;
        buf_id = 32'd3;
        poked = 1'b1;
      end else begin
        read_buf = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    read_buf = 1'b0;
    bus.pix_ready = 1'b1;
    if (k >= 400) check("frame_done_timeout", 32'(k), 32'd0);
    check("handshakes", 32'(hs_count), 32'd8);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    if (hs_cyc.size() == 8) begin
      check("first_latency", 32'(hs_cyc[0] - c0), 32'(3 + wait_n));
      for (int i = 1; i < 8; i++)
        check("pixel_interval", 32'(hs_cyc[i] - hs_cyc[i-1]),
              32'(3 + wait_n + ((i == stall_pix) ? stall_len : 0)));
      check("buf_read_delay", 32'(buf_read_cyc - hs_cyc[7]), 32'd1);
    end
    check("strobe_cycles", 32'(strobe_cnt), 32'(8 * (1 + wait_n)));
    check("rd_error_at_done", 32'(err_at_done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_frame", 32'(busy), 32'd0);
    check("single_buf_read", 32'(buf_read_cnt - br0), 32'd1);
    exp_q.delete();
  endtask

  task automatic reset_mid_frame();
    int k;
    ack_wait = 0;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{data: 24'(4 * i), eol: (i % 4 == 3), eof: (i == 7)});
    hs_count = 0;
    bus.pix_ready = 1'b1;
    @(posedge clk); #1;
    buf_id = 32'd0;
    read_buf = 1'b1;
    @(posedge clk); #1;
    read_buf = 1'b0;
    k = 0;
    while (!(hs_count == 5 && bus.wbm_strobe) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_pixel5_read", 32'(k < 100), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_strobe", 32'(bus.wbm_strobe), 32'd0);
    check("mrst_cycle", 32'(bus.wbm_cycle), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(bus.pix_valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mrst_addr_cleared", 32'(bus.wbm_address), 32'd0);
    check("mrst_pix_cleared", 32'(bus.pix_data), 32'd0);
    check("mrst_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe", 32'(bus.wbm_strobe), 32'd0);
    check("rst_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_buf_read", 32'(buf_read), 32'd0);
    check("rst_rd_error", 32'(rd_error), 32'd0);
    check("rst_write", 32'(bus.wbm_write), 32'd0);
    check("rst_writedata", bus.wbm_writedata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_addr", 32'(bus.wbm_address), 32'd0);
    check("post_rst_pix", 32'(bus.pix_data), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    run_frame(32'd0, 0, -1, 0, -1);   // full frame, base 0
    run_frame(32'd2, 0, 2, 5, -1);    // backpressure on pixel 2, base 64
    run_frame(32'd1, 4, -1, 0, -1);   // 4 wait states per read, base 32
    run_frame(32'd1, 0, -1, 0, 3);    // start request mid-frame is ignored
    reset_mid_frame();
    run_frame(32'd0, 0, -1, 0, -1);   // restart from pixel 0 after reset

`ifdef BUF_READER_ACK_TIMEOUT_EN
    begin
      int br0, k;
      never_ack = 1'b1;
      strobe_cnt = 0;
      valid_cnt = 0;
      br0 = buf_read_cnt;
      @(posedge clk); #1;
      buf_id = 32'd0;
      read_buf = 1'b1;
      @(posedge clk); #1;
      read_buf = 1'b0;
      k = 0;
      while (buf_read_cnt == br0 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      check("to_buf_read", 32'(buf_read_cnt - br0), 32'd1);
      check("to_strobe_cycles", 32'(strobe_cnt), 32'd8);
      check("to_no_valid", 32'(valid_cnt), 32'd0);
      check("to_rd_error_at_done", 32'(err_at_done), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("to_rd_error_sticky", 32'(rd_error), 32'd1);
      never_ack = 1'b0;
      run_frame(32'd0, 0, -1, 0, -1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
